// File: rtl/apb_reg_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_reg_bank_pkg
// Description : Shared types and constants for the APB register bank:
//               handshake FSM state, address decode result, register
//               stride, wait-counter width and a byte-lane merge helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package apb_reg_bank_pkg;

   // Byte distance between consecutive registers.
   localparam int REG_STRIDE = 4;

   // Width of the wait-state counter (supports 0..15 wait states).
   localparam int WAIT_CNT_W = 4;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } fsm_state_t;

   typedef enum logic [1:0] {
      OK      = 2'd0,
      DEC_ERR = 2'd1,
      RO_ERR  = 2'd2
   } dec_result_t;

   // Replace the byte lanes of cur selected by strb with the matching
   // lanes of wdata. Callers narrower than 32 bits zero-extend in and
   // truncate out, so strobe bits above the register width drop away.
   function automatic logic [31:0] merge_bytes(
      input logic [31:0] cur,
      input logic [31:0] wdata,
      input logic [3:0]  strb
   );
      logic [31:0] res;
      res = cur;
      for (int k = 0; k < 4; k++) begin
         if (strb[k]) begin
            res[8*k +: 8] = wdata[8*k +: 8];
         end
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/apb_slave_fsm.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_fsm
// Description : APB slave handshake engine. Tracks SETUP/ACCESS phases,
//               inserts WAIT_STATES extra access cycles, abandons the
//               transfer when psel drops, and raises pready for exactly
//               one cycle when the transfer completes. That pready cycle
//               doubles as the completion strobe for the register bank.
// Ports       : i_clk      - clock
//               i_rst      - synchronous active-high reset
//               i_psel     - APB select
//               i_penable  - APB enable
//               o_pready   - transfer complete (one-cycle strobe)
// Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_fsm
   import apb_reg_bank_pkg::*;
#(
   parameter int WAIT_STATES = 0
)
(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_psel,
   input  logic i_penable,
   output logic o_pready
);

   fsm_state_t              r_state;
   fsm_state_t              w_state_nxt;
   logic [WAIT_CNT_W-1:0]   r_wait;
   logic [WAIT_CNT_W-1:0]   w_wait_nxt;
   logic                    w_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_wait  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_wait  <= w_wait_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_wait_nxt  = r_wait;
      w_ready     = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_psel && !i_penable) begin
               w_state_nxt = ACCESS;
               w_wait_nxt  = WAIT_CNT_W'(WAIT_STATES);
            end
         end
         ACCESS: begin
            if (!i_psel) begin
               // Master abandoned the transfer: nothing completes.
               w_state_nxt = IDLE;
               w_wait_nxt  = '0;
            end else if (r_wait == '0) begin
               if (i_penable) begin
                  w_ready     = 1'b1;
                  w_state_nxt = IDLE;
               end
            end else begin
               w_wait_nxt = r_wait - WAIT_CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_wait_nxt  = '0;
         end
      endcase
   end

   // A reset arriving in what would be the completion cycle must kill the
   // strobe, otherwise the bank would commit a write while being reset.
   assign o_pready = w_ready && !i_rst;

endmodule
`default_nettype wire

// File: rtl/apb_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : apb_reg_bank
// Description : Parametrised APB slave register bank. NUM_REGS registers
//               at BASE_ADDR + 4*i, each read/write or read-only (RO_MASK).
//               Supports wait states, byte strobes, pslverr on decode or
//               read-only write errors, and per-register write pulses.
//               Optional macro APB_REG_BANK_SHADOW_EN: writes land in a
//               shadow copy that is transferred to data_system_o on
//               commit_i (with write bypass in the commit cycle).
// Ports       : pclk          - clock
//               reset         - synchronous active-high reset
//               psel/penable/pwrite/paddr/pwdata/pstrb - APB request
//               pready/pslverr/prdata                  - APB response
//               status_i      - read values for read-only registers
//               commit_i      - shadow commit pulse (shadow build only)
//               data_system_o - register contents to system logic
//               wr_pulse_o    - one-cycle pulse after a write to reg i
// Revision    : 1.0 - initial release
// ============================================================================
module apb_reg_bank
   import apb_reg_bank_pkg::*;
#(
   parameter int                                       NUM_REGS          = 8,
   parameter int                                       DATA_BUS_WIDTH    = 32,
   parameter int                                       ADDRESS_BUS_WIDTH = 16,
   parameter logic [ADDRESS_BUS_WIDTH-1:0]             BASE_ADDR         = '0,
   parameter logic [NUM_REGS*DATA_BUS_WIDTH-1:0]       RESET_VALUES      = '0,
   parameter logic [NUM_REGS-1:0]                      RO_MASK           = '0,
   parameter int                                       WAIT_STATES       = 0
)
(
   input  logic                                 pclk,
   input  logic                                 reset,
   input  logic                                 psel,
   input  logic                                 penable,
   input  logic                                 pwrite,
   input  logic [ADDRESS_BUS_WIDTH-1:0]         paddr,
   input  logic [31:0]                          pwdata,
   input  logic [3:0]                           pstrb,
   output logic                                 pready,
   output logic                                 pslverr,
   output logic [31:0]                          prdata,
   input  logic [NUM_REGS*DATA_BUS_WIDTH-1:0]   status_i,
   input  logic                                 commit_i,
   output logic [NUM_REGS*DATA_BUS_WIDTH-1:0]   data_system_o,
   output logic [NUM_REGS-1:0]                  wr_pulse_o
);

   localparam int DW    = DATA_BUS_WIDTH;
   localparam int AW    = ADDRESS_BUS_WIDTH;
   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   logic                  w_pready;
   logic [AW-1:0]         w_off;
   logic [AW-1:0]         w_idx_full;
   logic [IDX_W-1:0]      w_idx;
   logic                  w_ro_sel;
   dec_result_t           w_dec;
   logic                  w_write;
   logic [DW-1:0]         w_rd_reg;
   logic [NUM_REGS-1:0]   w_wr_vec;
   logic [NUM_REGS-1:0]   r_wr_pulse;
   logic [DW-1:0]         w_live   [NUM_REGS];
   logic [DW-1:0]         w_rd_src [NUM_REGS];

   apb_slave_fsm #(
      .WAIT_STATES (WAIT_STATES)
   ) u_fsm (
      .i_clk     (pclk),
      .i_rst     (reset),
      .i_psel    (psel),
      .i_penable (penable),
      .o_pready  (w_pready)
   );

   // ---------------------------------------------------------------------
   // Address decode. The offset wraps when paddr < BASE_ADDR, so that case
   // is flagged explicitly rather than relying on the range check.
   // ---------------------------------------------------------------------
   assign w_off      = paddr - BASE_ADDR;
   assign w_idx_full = w_off >> $clog2(REG_STRIDE);
   assign w_idx      = w_idx_full[IDX_W-1:0];

   // Index lookup written as a compare loop so that indices beyond
   // NUM_REGS (non power-of-two banks) never select a missing element.
   always_comb begin
      w_ro_sel = 1'b0;
      w_rd_reg = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (w_idx == IDX_W'(i)) begin
            w_ro_sel = RO_MASK[i];
            w_rd_reg = RO_MASK[i] ? status_i[i*DW +: DW] : w_rd_src[i];
         end
      end
   end

   always_comb begin
      w_dec = OK;
      if ((paddr < BASE_ADDR) || (paddr[1:0] != 2'b00) ||
          (w_idx_full >= AW'(NUM_REGS))) begin
         w_dec = DEC_ERR;
      end else if (pwrite && w_ro_sel) begin
         w_dec = RO_ERR;
      end
   end

   assign w_write = w_pready && pwrite && (w_dec == OK);

   always_comb begin
      w_wr_vec = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         w_wr_vec[i] = w_write && (w_idx == IDX_W'(i));
      end
   end

   always_ff @(posedge pclk) begin
      if (reset) begin
         r_wr_pulse <= '0;
      end else begin
         r_wr_pulse <= w_wr_vec;
      end
   end

   // ---------------------------------------------------------------------
   // Register storage
   // ---------------------------------------------------------------------
   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      localparam logic [DW-1:0] RST_VAL = RESET_VALUES[i*DW +: DW];

      if (RO_MASK[i]) begin : g_ro
         // Read-only: the system sees the reset constant; reads use status_i.
         assign w_live[i]   = RST_VAL;
         assign w_rd_src[i] = RST_VAL;
      end else begin : g_rw
         logic [DW-1:0] r_live;
         logic [DW-1:0] w_merged;
`ifdef APB_REG_BANK_SHADOW_EN
         logic [DW-1:0] r_shadow;

         assign w_merged = DW'(merge_bytes(32'(r_shadow), pwdata, pstrb));

         always_ff @(posedge pclk) begin
            if (reset) begin
               r_shadow <= RST_VAL;
               r_live   <= RST_VAL;
            end else begin
               if (w_wr_vec[i]) begin
                  r_shadow <= w_merged;
               end
               // A write landing in the commit cycle goes straight through.
               if (commit_i) begin
                  r_live <= w_wr_vec[i] ? w_merged : r_shadow;
               end
            end
         end

         assign w_rd_src[i] = r_shadow;
`else
         assign w_merged = DW'(merge_bytes(32'(r_live), pwdata, pstrb));

         always_ff @(posedge pclk) begin
            if (reset) begin
               r_live <= RST_VAL;
            end else if (w_wr_vec[i]) begin
               r_live <= w_merged;
            end
         end

         assign w_rd_src[i] = r_live;
`endif
         assign w_live[i] = r_live;
      end

      assign data_system_o[i*DW +: DW] = w_live[i];
   end : g_reg

`ifndef APB_REG_BANK_SHADOW_EN
   // commit_i only has meaning in the shadow build.
   logic w_unused;
   assign w_unused = commit_i;
`endif

   // ---------------------------------------------------------------------
   // APB response
   // ---------------------------------------------------------------------
   assign pready     = w_pready;
   assign pslverr    = w_pready && (w_dec != OK);
   assign prdata     = (w_pready && !pwrite && (w_dec == OK)) ? 32'(w_rd_reg) : 32'h0;
   assign wr_pulse_o = r_wr_pulse;

endmodule
`default_nettype wire

// File: tb/tb_apb_reg_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_apb_reg_bank
// Description : Directed bench for apb_reg_bank. Two instances share the
//               APB bus: u_dut0 with zero wait states and u_dut3 with three.
//               Register 1 is read-only, base address is 16'h0100.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_reg_bank;

   localparam int                NR   = 8;
   localparam int                DW   = 32;
   localparam logic [15:0]       BASE = 16'h0100;
   localparam logic [NR*DW-1:0]  RSTV = {{6{32'h0}}, 32'h1111_0001, 32'hAABB_CCDD};
   localparam logic [NR-1:0]     ROM  = 8'b0000_0010;
`ifdef APB_REG_BANK_SHADOW_EN
   localparam bit SHADOW = 1'b1;
`else
   localparam bit SHADOW = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset, psel0, psel3, penable, pwrite, commit;
   logic [15:0]       paddr;
   logic [31:0]       pwdata;
   logic [3:0]        pstrb;
   logic [NR*DW-1:0]  status;

   logic              pready0, pslverr0, pready3, pslverr3;
   logic [31:0]       prdata0, prdata3;
   logic [NR*DW-1:0]  dso0, dso3;
   logic [NR-1:0]     wrp0, wrp3;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   apb_reg_bank #(
      .NUM_REGS(NR), .DATA_BUS_WIDTH(DW), .ADDRESS_BUS_WIDTH(16),
      .BASE_ADDR(BASE), .RESET_VALUES(RSTV), .RO_MASK(ROM), .WAIT_STATES(0)
   ) u_dut0 (
      .pclk(clk), .reset(reset), .psel(psel0), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready0),
      .pslverr(pslverr0), .prdata(prdata0), .status_i(status), .commit_i(commit),
      .data_system_o(dso0), .wr_pulse_o(wrp0)
   );

   apb_reg_bank #(
      .NUM_REGS(NR), .DATA_BUS_WIDTH(DW), .ADDRESS_BUS_WIDTH(16),
      .BASE_ADDR(BASE), .RESET_VALUES(RSTV), .RO_MASK(ROM), .WAIT_STATES(3)
   ) u_dut3 (
      .pclk(clk), .reset(reset), .psel(psel3), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready3),
      .pslverr(pslverr3), .prdata(prdata3), .status_i(status), .commit_i(commit),
      .data_system_o(dso3), .wr_pulse_o(wrp3)
   );

   function automatic logic [31:0] slot(input logic [NR*DW-1:0] v, input int i);
      return v[i*32 +: 32];
   endfunction

   // One complete APB transfer, starting at posedge+1 and returning at
   // posedge+1 of the cycle after pready. cyc = access cycle that saw
   // pready (1 = zero-wait), 0 if pready never came within the budget.
   task automatic xfer(input bit d3, input bit wr, input logic [15:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       output int cyc, output logic [31:0] rdata, output logic err);
      cyc = 0; rdata = 'x; err = 1'bx;
      paddr = addr; pwrite = wr; pwdata = wdata; pstrb = strb; penable = 1'b0;
      if (d3) psel3 = 1'b1; else psel0 = 1'b1;
      @(posedge clk); #1;
      penable = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if ((d3 ? pready3 : pready0) === 1'b1) begin
            cyc   = n;
            rdata = d3 ? prdata3 : prdata0;
            err   = d3 ? pslverr3 : pslverr0;
         end
         @(posedge clk); #1;
         if (cyc != 0) break;
      end
      psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         vectors++;
         if (slot(d ? dso3 : dso0, 0) !== 32'hAABB_CCDD) begin
            miscompares++;
            $display("FAIL reset_reg0 dut%0d: got %h expected aabbccdd", d, slot(d ? dso3 : dso0, 0));
         end
         vectors++;
         if (slot(d ? dso3 : dso0, 1) !== 32'h1111_0001) begin
            miscompares++;
            $display("FAIL reset_reg1 dut%0d: got %h expected 11110001", d, slot(d ? dso3 : dso0, 1));
         end
         vectors++;
         if ({(d ? pready3 : pready0), (d ? pslverr3 : pslverr0), (d ? wrp3 : wrp0), (d ? prdata3 : prdata0)} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs dut%0d: pready %b pslverr %b wr_pulse %b prdata %h, expected all 0",
                     d, d ? pready3 : pready0, d ? pslverr3 : pslverr0, d ? wrp3 : wrp0, d ? prdata3 : prdata0);
         end
      end
   endtask

   task automatic test_reset_abort;
      paddr = BASE + 16'd8; pwrite = 1'b1; pwdata = 32'hDEAD_BEEF; pstrb = 4'hF;
      psel3 = 1'b1; penable = 1'b0;
      @(posedge clk); #1 penable = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;                       // completion cycle of the transfer
      @(negedge clk);
      vectors++;
      if (pready3 !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_abort_pready: got %b expected 0", pready3);
      end
      @(posedge clk); #1;
      reset = 1'b0; psel3 = 1'b0; penable = 1'b0;
      @(negedge clk);
      vectors++;
      if (wrp3 !== 8'h00 || slot(dso3, 2) !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_abort_write: wr_pulse %b reg2 %h, expected 00000000 / 00000000", wrp3, slot(dso3, 2));
      end
   endtask

   task automatic test_write_ws0;
      int cyc; logic [31:0] rd; logic err;
      xfer(1'b0, 1'b1, BASE + 16'd8, 32'h1234_5678, 4'b0011, cyc, rd, err);
      vectors++;
      if (cyc != 1 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL ws0_write_handshake: cycle %0d pslverr %b, expected 1 / 0", cyc, err);
      end
      @(negedge clk);
      vectors++;
      if (slot(dso0, 2) !== (SHADOW ? 32'h0 : 32'h0000_5678)) begin
         miscompares++;
         $display("FAIL ws0_write_data: got %h expected %h", slot(dso0, 2), SHADOW ? 32'h0 : 32'h0000_5678);
      end
      vectors++;
      if (wrp0 !== 8'b0000_0100) begin
         miscompares++;
         $display("FAIL ws0_write_pulse: got %b expected 00000100", wrp0);
      end
      @(negedge clk);
      vectors++;
      if (wrp0 !== 8'b0) begin
         miscompares++;
         $display("FAIL ws0_pulse_width: got %b expected 00000000", wrp0);
      end
      // Upper-lane strobes merge into the existing value.
      xfer(1'b0, 1'b1, BASE + 16'd8, 32'h9ABC_0000, 4'b1100, cyc, rd, err);
      xfer(1'b0, 1'b0, BASE + 16'd8, 32'h0, 4'h0, cyc, rd, err);
      vectors++;
      if (rd !== 32'h9ABC_5678) begin
         miscompares++;
         $display("FAIL ws0_strobe_merge: got %h expected 9abc5678", rd);
      end
      // pstrb = 0 changes nothing but still pulses.
      xfer(1'b0, 1'b1, BASE + 16'd12, 32'hFFFF_FFFF, 4'b0000, cyc, rd, err);
      @(negedge clk);
      vectors++;
      if (wrp0 !== 8'b0000_1000) begin
         miscompares++;
         $display("FAIL ws0_zero_strobe_pulse: got %b expected 00001000", wrp0);
      end
      xfer(1'b0, 1'b0, BASE + 16'd12, 32'h0, 4'h0, cyc, rd, err);
      vectors++;
      if (rd !== 32'h0) begin
         miscompares++;
         $display("FAIL ws0_zero_strobe_data: got %h expected 00000000", rd);
      end
   endtask

   task automatic test_read_ws3;
      int cyc; logic [31:0] rd; logic err;
      xfer(1'b1, 1'b1, BASE + 16'd8, 32'h1234_5678, 4'b0011, cyc, rd, err);
      vectors++;
      if (cyc != 4) begin
         miscompares++;
         $display("FAIL ws3_write_latency: pready on access cycle %0d, expected 4", cyc);
      end
      xfer(1'b1, 1'b0, BASE + 16'd8, 32'h0, 4'h0, cyc, rd, err);
      vectors++;
      if (cyc != 4 || rd !== 32'h0000_5678 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL ws3_read: cycle %0d prdata %h pslverr %b, expected 4 / 00005678 / 0", cyc, rd, err);
      end
   endtask

   task automatic test_errors;
      int cyc; logic [31:0] rd; logic err;
      logic [15:0] bad [4];
      bad[0] = BASE + 16'd32;   // one past the last register
      bad[1] = BASE + 16'd2;    // misaligned
      bad[2] = BASE + 16'd4;    // read-only register
      bad[3] = BASE - 16'd4;    // below base
      for (int t = 0; t < 4; t++) begin
         xfer(1'b0, 1'b1, bad[t], 32'hFFFF_FFFF, 4'hF, cyc, rd, err);
         vectors++;
         if (cyc != 1 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_write_%h: cycle %0d pslverr %b, expected 1 / 1", bad[t], cyc, err);
         end
         @(negedge clk);
         vectors++;
         if (wrp0 !== 8'b0 || slot(dso0, 1) !== 32'h1111_0001) begin
            miscompares++;
            $display("FAIL err_side_effect_%h: wr_pulse %b reg1 %h, expected 00000000 / 11110001", bad[t], wrp0, slot(dso0, 1));
         end
      end
      xfer(1'b0, 1'b0, BASE, 32'h0, 4'h0, cyc, rd, err);
      vectors++;
      if (rd !== 32'hAABB_CCDD) begin
         miscompares++;
         $display("FAIL err_reg0_intact: got %h expected aabbccdd", rd);
      end
      xfer(1'b0, 1'b0, BASE + 16'd32, 32'h0, 4'h0, cyc, rd, err);
      vectors++;
      if (err !== 1'b1 || rd !== 32'h0) begin
         miscompares++;
         $display("FAIL err_read: pslverr %b prdata %h, expected 1 / 00000000", err, rd);
      end
   endtask

   task automatic test_ro_read_abort;
      int cyc; logic [31:0] rd; logic err; logic seen;
      status = '0;
      status[63:32] = 32'hCAFE_0001;
      xfer(1'b1, 1'b0, BASE + 16'd4, 32'h0, 4'h0, cyc, rd, err);
      vectors++;
      if (cyc != 4 || rd !== 32'hCAFE_0001 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL ro_read: cycle %0d prdata %h pslverr %b, expected 4 / cafe0001 / 0", cyc, rd, err);
      end
      vectors++;
      if (slot(dso3, 1) !== 32'h1111_0001) begin
         miscompares++;
         $display("FAIL ro_system_value: got %h expected 11110001", slot(dso3, 1));
      end
      // Abandon a write to reg4 while wait states are still counting.
      paddr = BASE + 16'd16; pwrite = 1'b1; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
      psel3 = 1'b1; penable = 1'b0;
      @(posedge clk); #1 penable = 1'b1;
      @(posedge clk); #1;
      psel3 = 1'b0; penable = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         if (pready3 !== 1'b0 || wrp3 !== 8'b0) seen = 1'b1;
      end
      @(posedge clk); #1;
      vectors++;
      if (seen !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_activity: got pready/pulse activity %b expected 0", seen);
      end
      xfer(1'b1, 1'b0, BASE + 16'd16, 32'h0, 4'h0, cyc, rd, err);
      vectors++;
      if (cyc != 4 || rd !== 32'h0) begin
         miscompares++;
         $display("FAIL abort_recovery: cycle %0d prdata %h, expected 4 / 00000000", cyc, rd);
      end
   endtask

   task automatic test_back_to_back;
      int cyc; logic [31:0] rd; logic err;
      xfer(1'b0, 1'b1, BASE + 16'd20, 32'hA5A5_A5A5, 4'hF, cyc, rd, err);
      xfer(1'b0, 1'b0, BASE + 16'd20, 32'h0, 4'h0, cyc, rd, err);
      vectors++;
      if (cyc != 1 || rd !== 32'hA5A5_A5A5) begin
         miscompares++;
         $display("FAIL b2b_read_after_write: cycle %0d prdata %h, expected 1 / a5a5a5a5", cyc, rd);
      end
      xfer(1'b0, 1'b1, BASE + 16'd24, 32'h0F0F_0F0F, 4'hF, cyc, rd, err);
      xfer(1'b0, 1'b1, BASE + 16'd28, 32'h7654_3210, 4'hF, cyc, rd, err);
      xfer(1'b0, 1'b0, BASE + 16'd24, 32'h0, 4'h0, cyc, rd, err);
      vectors++;
      if (rd !== 32'h0F0F_0F0F) begin
         miscompares++;
         $display("FAIL b2b_reg6: got %h expected 0f0f0f0f", rd);
      end
      xfer(1'b0, 1'b0, BASE + 16'd28, 32'h0, 4'h0, cyc, rd, err);
      vectors++;
      if (rd !== 32'h7654_3210) begin
         miscompares++;
         $display("FAIL b2b_reg7: got %h expected 76543210", rd);
      end
   endtask

`ifdef APB_REG_BANK_SHADOW_EN
   task automatic test_shadow;
      int cyc; logic [31:0] rd; logic err;
      xfer(1'b0, 1'b1, BASE, 32'h0000_0055, 4'hF, cyc, rd, err);
      @(negedge clk);
      vectors++;
      if (slot(dso0, 0) !== 32'hAABB_CCDD) begin
         miscompares++;
         $display("FAIL shadow_precommit_live: got %h expected aabbccdd", slot(dso0, 0));
      end
      xfer(1'b0, 1'b0, BASE, 32'h0, 4'h0, cyc, rd, err);
      vectors++;
      if (rd !== 32'h0000_0055) begin
         miscompares++;
         $display("FAIL shadow_readback: got %h expected 00000055", rd);
      end
      commit = 1'b1;
      @(posedge clk); #1 commit = 1'b0;
      @(negedge clk);
      vectors++;
      if (slot(dso0, 0) !== 32'h0000_0055) begin
         miscompares++;
         $display("FAIL shadow_commit: got %h expected 00000055", slot(dso0, 0));
      end
      commit = 1'b1;
      xfer(1'b0, 1'b1, BASE, 32'h0000_0066, 4'hF, cyc, rd, err);
      commit = 1'b0;
      @(negedge clk);
      vectors++;
      if (slot(dso0, 0) !== 32'h0000_0066) begin
         miscompares++;
         $display("FAIL shadow_bypass: got %h expected 00000066", slot(dso0, 0));
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
      commit = 1'b0; paddr = '0; pwdata = '0; pstrb = '0; status = '0;
      test_reset();
      test_reset_abort();
      test_write_ws0();
      test_read_ws3();
      test_errors();
      test_ro_read_abort();
      test_back_to_back();
`ifdef APB_REG_BANK_SHADOW_EN
      test_shadow();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/apb_reg_bank.md
Name: apb_reg_bank

Overview:
- Parametrised APB slave register bank. Successor to the single-address APB configuration register.
- Holds NUM_REGS registers at consecutive word addresses. Each register is read/write (control) or read-only (status), selected by RO_MASK.
- Adds configurable wait states, byte strobes, error response (pslverr) and per-register write pulses.
- Sits between the APB interconnect and the system logic (I2C core configuration/status).

Parameters:
- NUM_REGS, 8, number of registers (1..64).
- DATA_BUS_WIDTH, 32, register width; multiple of 8, at most 32.
- ADDRESS_BUS_WIDTH, 16, paddr width.
- BASE_ADDR, 16'h0000, byte address of register 0; register i sits at BASE_ADDR+4*i.
- RESET_VALUES, {NUM_REGS{32'h0}}, flattened reset values; register i uses bits [i*DATA_BUS_WIDTH +: DATA_BUS_WIDTH].
- RO_MASK, {NUM_REGS{1'b0}}, bit i=1 makes register i read-only.
- WAIT_STATES, 0, extra ACCESS cycles before pready (0..15).

Ports:
- pclk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- psel  in  1  APB select.
- penable  in  1  APB enable.
- pwrite  in  1  1=write, 0=read.
- paddr  in  ADDRESS_BUS_WIDTH  byte address.
- pwdata  in  32  write data.
- pstrb  in  4  byte write strobes.
- pready  out  1  transfer complete.
- pslverr  out  1  error response; valid only while pready=1.
- prdata  out  32  read data; valid while pready=1 and pwrite=0.
- status_i  in  NUM_REGS*DATA_BUS_WIDTH  read values for RO registers.
- commit_i  in  1  shadow commit pulse (optional feature only).
- data_system_o  out  NUM_REGS*DATA_BUS_WIDTH  register contents to system logic.
- wr_pulse_o  out  NUM_REGS  one-cycle pulse on a successful write to register i.

Behaviour:
- Reset (sync, reset=1 at posedge pclk):
  - FSM goes to IDLE and the wait counter clears.
  - Every register loads its RESET_VALUES slice.
  - pready, pslverr, wr_pulse_o and prdata are 0.
- No tristate outputs. All outputs are driven to 0 when inactive.
- FSM states: IDLE, ACCESS.
  - IDLE -> ACCESS on psel=1, penable=0 (setup phase). The wait counter loads WAIT_STATES.
  - In ACCESS, the counter decrements each cycle while nonzero.
  - pready=1 when state=ACCESS, counter=0 and psel=penable=1. This is combinational from registered state.
  - ACCESS -> IDLE in the pready cycle.
  - ACCESS -> IDLE if psel drops before completion (abort). An aborted transfer has no write, no pulse and no error.
- Latency: setup cycle + (WAIT_STATES+1) access cycles. With WAIT_STATES=0 this is standard zero-wait APB.
- Back-to-back transfers: a new setup phase in the cycle after pready is accepted with no idle gap.
- Address decode:
  - idx = (paddr-BASE_ADDR)>>2.
  - Error if paddr<BASE_ADDR, idx>=NUM_REGS, or paddr[1:0]!=0.
- Error response: pslverr=1 together with pready for:
  - a decode error, or
  - a write to an RO register.
  - On error there is no state change, no wr_pulse_o, and prdata=0.
- Write (pready cycle, no error):
  - Byte k of register idx takes pwdata[8k+7:8k] where pstrb[k]=1, for k < DATA_BUS_WIDTH/8.
  - pstrb bits above the register width are ignored.
  - pstrb=0 is legal: no data change, but wr_pulse_o still fires.
  - Update is visible on data_system_o the next cycle.
  - wr_pulse_o[idx] is high for exactly the cycle after the pready cycle.
- Read: prdata is zero-extended to 32 bits.
  - RW register: current register value.
  - RO register: status_i slice, sampled combinationally.
- RO registers: data_system_o slice stays constant at its RESET_VALUES slice.
- Reset during ACCESS aborts the transfer. No write occurs, and pready is 0 in the reset cycle.

Optional Feature:
- Macro: APB_REG_BANK_SHADOW_EN.
- Defined:
  - Writes update a shadow copy; reads of RW registers return the shadow.
  - data_system_o loads all shadows on a cycle with commit_i=1.
  - A write in the same cycle as commit_i: data_system_o takes the newly written value (bypass).
  - Reset loads both shadow and live copies.
- Undefined: commit_i is ignored. Writes go directly to data_system_o, as described above.

Decomposition:
- Package apb_reg_bank_pkg holds:
  - FSM state typedef (IDLE, ACCESS).
  - REG_STRIDE=4.
  - Wait-counter width constant (4).
  - Decode-result typedef {OK, DEC_ERR, RO_ERR}.
- Sub-module apb_slave_fsm owns handshake, wait counter, abort and pready generation. It outputs a one-cycle complete strobe.
- The bank itself handles decode, storage, strobes and shadow logic.

Test Plan:
1. Reset with RESET_VALUES reg0=32'hAABBCCDD -> data_system_o[31:0]=32'hAABBCCDD; pready=pslverr=0.
2. WAIT_STATES=0: write 32'h12345678 to BASE+8, pstrb=4'b0011 (reg2 was 0) -> pready in 2nd cycle; reg2=32'h00005678 next cycle; wr_pulse_o=8'b00000100 for one cycle.
3. WAIT_STATES=3: read reg2 -> pready asserted on the 4th ACCESS cycle; prdata=32'h00005678; pslverr=0.
4. Write to BASE+4*NUM_REGS, to BASE+2, and to an RO register -> each gives pready=1, pslverr=1, no register change, no pulse.
5. Read RO reg1 with status_i slice=32'hCAFE0001 -> prdata=32'hCAFE0001. Drop psel mid-wait -> FSM returns to IDLE; no pready.
6. APB_REG_BANK_SHADOW_EN: write 32'h55 to reg0 -> data_system_o unchanged until the commit_i pulse, then 32'h55. Readback returns 32'h55 before commit.
